// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pkg
// Description : Shared types and constants for the instruction fetch unit:
//               FSM state encoding, default reset PC, instruction field
//               positions and a word-alignment helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_ERROR = 2'd2
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pc_reg
// Description : Program counter register with next-PC selection.
//               Priority: flush > accept (branch target or PC+4) > hold.
// Ports       : clk_i, rst_i (async, active-low)
//               i_flush, i_flush_pc       - redirect request and target
//               i_accept                  - current instruction consumed
//               i_branch, i_branch_target - taken branch for that instruction
//               o_pc                      - current PC
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_pc_reg
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  input  logic        i_accept,
  input  logic        i_branch,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;

  always_comb begin
    w_pc_next = r_pc;
    if (i_flush) begin
      w_pc_next = i_flush_pc;
    end else if (i_accept) begin
      // Unsigned add wraps 32'hFFFF_FFFC -> 0 naturally.
      w_pc_next = i_branch ? i_branch_target : (r_pc + 32'd4);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch stage. Holds the PC, fetches from
//               instruction memory with a req/ack handshake, latches the
//               word into an instruction register and offers it to the
//               decoder with a valid/ready handshake.
//               Optional feature macro: IFU_ALIGN_CHECK_EN - misaligned
//               branch/flush targets raise sticky err_o and park in ERROR;
//               without it targets are forced word-aligned.
// Ports       : clk_i, rst_i (async, active-low)
//               imem_req_o/imem_addr_o/imem_ack_i/imem_data_i - memory side
//               instr_valid_o/instr_ready_i/instr_o/instr_op_o/funct_o,
//               pc_o/pc_plus4_o                               - decoder side
//               branch_i/branch_target_i/flush_i/flush_pc_i   - redirects
//               fetch_cnt_o - accepted-instruction count, err_o - align error
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [31:0]      imem_data_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [31:0]      instr_o,
  output logic [5:0]       instr_op_o,
  output logic [5:0]       funct_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  input  logic             branch_i,
  input  logic [31:0]      branch_target_i,
  input  logic             flush_i,
  input  logic [31:0]      flush_pc_i,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic             err_o
);

  ifu_state_e       r_state;
  logic [31:0]      r_instr;
  logic             r_valid;
  logic             r_kill;   // an abandoned fetch is still in flight
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic             w_accept;
  logic             w_flush;
  logic             w_align_err;
  logic [31:0]      w_branch_tgt;
  logic [31:0]      w_flush_tgt;
  logic [31:0]      w_pc;

  assign w_accept = (r_state == ST_HOLD) && instr_ready_i;
  assign w_flush  = flush_i && (r_state != ST_ERROR);

`ifdef IFU_ALIGN_CHECK_EN
  assign w_branch_tgt = branch_target_i;
  assign w_flush_tgt  = flush_pc_i;
  assign w_align_err  = (w_flush && (flush_pc_i[1:0] != 2'b00)) ||
                        (w_accept && branch_i && (branch_target_i[1:0] != 2'b00));
`else
  assign w_branch_tgt = align_word(branch_target_i);
  assign w_flush_tgt  = align_word(flush_pc_i);
  assign w_align_err  = 1'b0;
`endif

  ifu_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .i_flush         (w_flush),
    .i_flush_pc      (w_flush_tgt),
    .i_accept        (w_accept),
    .i_branch        (branch_i),
    .i_branch_target (w_branch_tgt),
    .o_pc            (w_pc)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_FETCH;
      r_instr <= 32'h0;
      r_valid <= 1'b0;
      r_kill  <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      // A consumed instruction counts even if a flush lands on the same edge.
      if (w_accept) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      if (w_align_err) begin
        r_state <= ST_ERROR;
        r_err   <= 1'b1;
        r_valid <= 1'b0;
        r_kill  <= 1'b0;
      end else if (w_flush) begin
        r_state <= ST_FETCH;
        r_valid <= 1'b0;
        // Only an un-acked fetch leaves a stale response to swallow; an ack
        // on the flush edge is simply dropped here.
        r_kill  <= (r_state == ST_FETCH) && !imem_ack_i;
      end else begin
        case (r_state)
          ST_FETCH: begin
            if (imem_ack_i) begin
              if (r_kill) begin
                r_kill <= 1'b0;
              end else begin
                r_instr <= imem_data_i;
                r_valid <= 1'b1;
                r_state <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (instr_ready_i) begin
              r_valid <= 1'b0;
              r_state <= ST_FETCH;
            end
          end
          ST_ERROR: begin
            r_valid <= 1'b0;
          end
          default: begin
            r_state <= ST_FETCH;
          end
        endcase
      end
    end
  end

  assign imem_req_o    = (r_state == ST_FETCH);
  assign imem_addr_o   = w_pc;
  assign instr_valid_o = r_valid;
  assign instr_o       = r_instr;
  assign instr_op_o    = r_instr[OP_MSB:OP_LSB];
  assign funct_o       = r_instr[FUNCT_MSB:FUNCT_LSB];
  assign pc_o          = w_pc;
  assign pc_plus4_o    = w_pc + 32'd4;
  assign fetch_cnt_o   = r_cnt;
  assign err_o         = r_err;

endmodule
`default_nettype wire
